stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Run/pause/clear controller for the stopwatch datapath (seconds counter chained to minutes counter, 00:00 to 99:59).
- Converts start/stop/reset command pulses into a three-plus-one-state FSM.
- Divides the system clock down to a one-cycle-per-second tick, which drives the seconds counter enable.
- Issues a one-cycle clear to both counters.
- Optionally freezes the display at 99:59 instead of wrapping.

Parameters:
TICK_DIV, 100_000_000, clock cycles per counted second; must be >= 2.
DIV_W, 27, prescaler width; must satisfy 2**DIV_W >= TICK_DIV.
SATURATE, 0, 1 = halt at 99:59; 0 = let counters wrap to 00:00.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle synchronous command: run/resume.
stop  input  1  single-cycle synchronous command: pause.
reset  input  1  single-cycle synchronous command: clear to 00:00 and idle.
at_max  input  1  from datapath: high while minutes==99 and seconds==59.
tick_en  output  1  one-cycle pulse to the seconds counter enable.
clr  output  1  one-cycle pulse to the counters' reset inputs.
running  output  1  high while state==RUN.
state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, HALT=3.

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low. While rst_n is low:
  - state=IDLE, prescaler p=0, tick_en=0, clr=0, running=0.
  - These values are forced without a clock edge.
  - clr is NOT pulsed on rst_n release; the counters receive rst_n themselves.
- All outputs are registered. running is decoded from the state register.
- Command priority within one cycle is reset > stop > start. A lower-priority command asserted together with a higher one is dropped.
- FSM:
  - IDLE:
    - start -> RUN, with p cleared to 0.
    - reset -> stay IDLE and pulse clr.
    - stop is ignored.
  - RUN:
    - reset -> IDLE, pulse clr, p=0.
    - stop -> PAUSE, p holds.
    - Otherwise p increments each cycle.
  - PAUSE:
    - start -> RUN; p is not cleared, so the fractional second is preserved.
    - reset -> IDLE, pulse clr, p=0.
    - stop is ignored.
  - HALT:
    - reset -> IDLE, pulse clr, p=0.
    - start and stop are ignored. p holds at 0, tick_en=0.
- Terminal count: state==RUN, p==TICK_DIV-1, and no reset/stop this cycle.
  - At the next edge p becomes 0.
  - If SATURATE==1 and at_max==1: state becomes HALT and tick_en stays 0, so the counters hold 99:59.
  - Otherwise tick_en=1 for exactly one cycle; counters advance, wrapping at 99:59 -> 00:00.
- stop or reset coincident with terminal count: no tick.
  - With stop, p holds at TICK_DIV-1, so a later resume ticks on the first RUN edge.
- Latency:
  - First tick_en after start from IDLE is high in the cycle following the TICK_DIV-th rising edge after the edge that sampled start. That is, ticks are exactly TICK_DIV cycles apart.
  - clr is high in the cycle after the edge that sampled reset, for one cycle.
  - tick_en and clr are never high together.
- at_max is sampled only at terminal count; it is ignored at all other times.

Decomposition:
- Package stopwatch_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_HALT=2'd3.
  - MAX_MIN=99 and MAX_SEC=59, shared with the counters' at_max generation.
- Sub-module stopwatch_prescaler (inputs: clk, rst_n, inc, clr; outputs: p, term):
  - inc = state is RUN and no stop/reset this cycle.
  - clr = transition into RUN from IDLE, or any reset.
  - term = (p==TICK_DIV-1), combinational.
- The FSM and output registers stay in stopwatch_ctrl.

Test Plan:
1. TICK_DIV=4. rst_n release, then start for one cycle at edge 0 -> state=1, running=1. tick_en pulses high in the cycles after edges 4, 8, 12; clr stays 0.
2. TICK_DIV=4, running. stop when p=2 -> state=2, no tick_en for 10 idle cycles. start at edge R -> tick_en after edge R+2. Then periodic every 4 cycles.
3. reset asserted in the same cycle as terminal count in RUN -> no tick_en. clr high for exactly one cycle after that edge. state=0, p=0. A following start gives the first tick 4 cycles later.
4. SATURATE=1, at_max=1 held, terminal count in RUN -> state=3, tick_en never pulses. start and stop are ignored for 20 cycles. reset -> state=0, clr pulse.
5. SATURATE=0, at_max=1 at terminal count -> tick_en pulses (counters wrap), state stays 1.
6. start and stop asserted together in IDLE -> state stays 0. Then rst_n driven low mid-RUN between clock edges -> state, tick_en, clr and running read 0 immediately, before the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and its datapath.
// State encoding is visible on the state output, so the values are fixed.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int MAX_MIN = 99;
  localparam int MAX_SEC = 59;

  // Datapath helper: true on the last displayable value, 99:59.
  function automatic logic isAtMax(input logic [6:0] minutes, input logic [5:0] seconds);
    return (minutes == 7'(MAX_MIN)) && (seconds == 6'(MAX_SEC));
  endfunction

endpackage

// File: rtl/stopwatch_prescaler.sv
// Divides the system clock down to one terminal count per counted second.
// The count freezes whenever inc is low, which preserves the fractional second.
module stopwatch_prescaler
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int DIV_W    = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [DIV_W-1:0] p,
  output logic             term
);

  localparam logic [DIV_W-1:0] LP_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_p;

  assign p    = r_p;
  assign term = (r_p == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (clr) begin
      r_p <= '0;
    end else if (inc) begin
      r_p <= term ? '0 : r_p + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for the mm:ss stopwatch datapath.
// Command priority is reset > stop > start; all outputs come from registers.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int DIV_W    = 27,
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  input  logic       at_max,
  output logic       tick_en,
  output logic       clr,
  output logic       running,
  output logic [1:0] state
);

  state_t           r_state;
  logic             r_tick;
  logic             r_clr;
  logic [DIV_W-1:0] w_unusedP;
  logic             w_term;
  logic             w_inc;
  logic             w_preClr;

  // The prescaler only advances in RUN with no stop or reset, so a stop on
  // terminal count leaves it at TICK_DIV-1 and a resume ticks immediately.
  assign w_inc    = (r_state == ST_RUN) && !stop && !reset;
  assign w_preClr = reset || ((r_state == ST_IDLE) && start && !stop);

  stopwatch_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .clr   (w_preClr),
    .p     (w_unusedP),
    .term  (w_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tick  <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_clr  <= 1'b0;
      if (reset) begin
        r_state <= ST_IDLE;
        r_clr   <= 1'b1;
      end else if (stop) begin
        if (r_state == ST_RUN) begin
          r_state <= ST_PAUSE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_term) begin
              if (SATURATE && at_max) begin
                r_state <= ST_HALT;
              end else begin
                r_tick <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (start) begin
              r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign tick_en = r_tick;
  assign clr     = r_clr;
  assign running = (r_state == ST_RUN);
  assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a wrapping and a saturating instance
// share stimulus, and a behavioural model predicts each cycle's outputs.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       reset = 1'b0;
  logic       atMax = 1'b0;
  logic       tick0, clr0, run0, tick1, clr1, run1;
  logic [1:0] st0, st1;

  typedef struct {
    int st0;
    bit tk0;
    bit cl0;
    int st1;
    bit tk1;
    bit cl1;
  } expT;

  expT expQ[$];
  int  mode[2];
  int  frac[2];
  bit  mTick[2];
  bit  mClr[2];
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(3), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .at_max(atMax), .tick_en(tick0), .clr(clr0), .running(run0), .state(st0)
  );

  stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(3), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .at_max(atMax), .tick_en(tick1), .clr(clr1), .running(run1), .state(st1)
  );

  // Model: mode 0 idle, 1 run, 2 pause, 3 halt; frac counts cycles into the second.
  task automatic modelStep(input int k, input bit s, input bit st, input bit r, input bit a);
    mTick[k] = 1'b0;
    mClr[k]  = 1'b0;
    if (r) begin
      mode[k] = 0;
      frac[k] = 0;
      mClr[k] = 1'b1;
    end else if (st) begin
      if (mode[k] == 1) mode[k] = 2;
    end else if (mode[k] == 1) begin
      if (frac[k] == TD - 1) begin
        frac[k] = 0;
        if (k == 1 && a) mode[k] = 3;
        else mTick[k] = 1'b1;
      end else begin
        frac[k] = frac[k] + 1;
      end
    end else if (s) begin
      if (mode[k] == 0) begin
        mode[k] = 1;
        frac[k] = 0;
      end else if (mode[k] == 2) begin
        mode[k] = 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit s, input bit st, input bit r, input bit a);
    expT e;
    @(negedge clk);
    start = s;
    stop  = st;
    reset = r;
    atMax = a;
    modelStep(0, s, st, r, a);
    modelStep(1, s, st, r, a);
    e.st0 = mode[0];
    e.tk0 = mTick[0];
    e.cl0 = mClr[0];
    e.st1 = mode[1];
    e.tk1 = mTick[1];
    e.cl1 = mClr[1];
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic compareOne(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input expT e);
    compareOne("wrap.state",   32'(st0),   32'(e.st0));
    compareOne("wrap.tick_en", 32'(tick0), 32'(e.tk0));
    compareOne("wrap.clr",     32'(clr0),  32'(e.cl0));
    compareOne("wrap.running", 32'(run0),  32'(e.st0 == 1));
    compareOne("sat.state",    32'(st1),   32'(e.st1));
    compareOne("sat.tick_en",  32'(tick1), 32'(e.tk1));
    compareOne("sat.clr",      32'(clr1),  32'(e.cl1));
    compareOne("sat.running",  32'(run1),  32'(e.st1 == 1));
  endtask

  task automatic checkAllZero(input string tag);
    compareOne({tag, ".state0"},   32'(st0),   32'd0);
    compareOne({tag, ".tick0"},    32'(tick0), 32'd0);
    compareOne({tag, ".clr0"},     32'(clr0),  32'd0);
    compareOne({tag, ".running0"}, 32'(run0),  32'd0);
    compareOne({tag, ".state1"},   32'(st1),   32'd0);
    compareOne({tag, ".tick1"},    32'(tick1), 32'd0);
    compareOne({tag, ".clr1"},     32'(clr1),  32'd0);
    compareOne({tag, ".running1"}, 32'(run1),  32'd0);
  endtask

  // rst_n drops between edges; outputs must clear without waiting for a clock.
  task automatic asyncReset();
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
    atMax = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkAllZero("async");
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0;
      frac[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : driver
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0;
      frac[k] = 0;
    end
    #2 checkAllZero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Free run: ticks after edges 4, 8, 12 of the run.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(13);
    // Pause mid-second, then resume keeps the fraction.
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    // Reset coincident with terminal count.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    // at_max held: saturating instance halts, wrapping one keeps ticking.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    // start with stop in idle is dropped; then async reset mid-run.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    asyncReset();

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0));
    end
    idle(1);

    @(posedge clk);
    #2;
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
